// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register index type, XZR constant, hazard FSM states.
// Contents:
//   RegW / CountW  register-index and performance-counter widths
//   regIdx_t       5-bit architectural register index
//   XZR            zero register (X31), never a true dependency
//   hazState_t     hazard unit FSM states {RUN, HOLD}
//   regHit()       dependency match that ignores XZR
package cpu_pkg;

    localparam int unsigned RegW   = 5;
    localparam int unsigned CountW = 16;

    typedef logic [RegW-1:0] regIdx_t;

    localparam regIdx_t XZR = 5'd31;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } hazState_t;

    // A producer/consumer pair only depends on each other when the register is not XZR.
    function automatic logic regHit(input regIdx_t dst, input regIdx_t src);
        return (dst == src) && (dst != XZR);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle.
// master: pipeline side, drives EX/MEM/ID status and MemBusy, receives controls.
// slave : hazard unit side, receives status, drives PC/IF-ID/ID-EX controls and counters.
interface hazard_unit_if;
    import cpu_pkg::*;

    logic           MemReadEX;
    logic           RegWriteEX;
    regIdx_t        WriteRegEX;
    logic           MemReadMEM;
    regIdx_t        WriteRegMEM;
    regIdx_t        RnID;
    regIdx_t        RmID;
    regIdx_t        RtID;
    logic           RmValidID;
    logic           ZeroBranchID;
    logic           BranchTakenID;
    logic           MemBusy;

    logic           PCWrite;
    logic           IFIDWrite;
    logic           BubbleID;
    logic           FlushIFID;
    logic [CountW-1:0] StallCount;
    logic [CountW-1:0] FlushCount;

    modport master (
        output MemReadEX, RegWriteEX, WriteRegEX, MemReadMEM, WriteRegMEM,
               RnID, RmID, RtID, RmValidID, ZeroBranchID, BranchTakenID, MemBusy,
        input  PCWrite, IFIDWrite, BubbleID, FlushIFID, StallCount, FlushCount
    );

    modport slave (
        input  MemReadEX, RegWriteEX, WriteRegEX, MemReadMEM, WriteRegMEM,
               RnID, RmID, RtID, RmValidID, ZeroBranchID, BranchTakenID, MemBusy,
        output PCWrite, IFIDWrite, BubbleID, FlushIFID, StallCount, FlushCount
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-high reset.
// Ports: clk, reset (sync, active-high), en (count this cycle), count (current value).
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [Width-1:0] count
);

    // Sticks at all-ones once reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + Width'(1);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use, CBZ and CBZ-after-load stalls, taken-branch
// flush, memory-busy freeze, optional stall/flush performance counters.
// Ports:
//   clk    pipeline clock
//   reset  synchronous active-high reset
//   hz     hazard_unit_if.slave (EX/MEM/ID status in; PCWrite, IFIDWrite,
//          BubbleID, FlushIFID, StallCount, FlushCount out)
// Build option: define HAZARD_PERF_EN to enable the saturating StallCount /
// FlushCount counters; otherwise both read as zero and no counter flops exist.
module hazard_unit
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    hazard_unit_if.slave  hz
);

    hazState_t  state;
    hazState_t  stateNext;
    logic [1:0] stallLeft;
    logic [1:0] stallLeftNext;

    logic loadUse;
    logic cbzHaz;
    logic cbzLoad;
    logic stall;

    // Hazard detection; XZR filtering lives in regHit().
    assign loadUse = hz.MemReadEX &
                     (regHit(hz.WriteRegEX, hz.RnID) |
                      (hz.RmValidID & regHit(hz.WriteRegEX, hz.RmID)));

    assign cbzHaz  = hz.ZeroBranchID &
                     ((hz.RegWriteEX & ~hz.MemReadEX & regHit(hz.WriteRegEX, hz.RtID)) |
                      (hz.MemReadMEM & regHit(hz.WriteRegMEM, hz.RtID)));

    assign cbzLoad = hz.ZeroBranchID & hz.MemReadEX & regHit(hz.WriteRegEX, hz.RtID);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            stallLeft <= 2'd0;
        end else begin
            state     <= stateNext;
            stallLeft <= stallLeftNext;
        end
    end

    // Next state and pipeline controls.
    always_comb begin
        stateNext     = state;
        stallLeftNext = stallLeft;
        stall         = 1'b0;

        case (state)
            RUN: begin
                if (loadUse | cbzHaz | cbzLoad) begin
                    stall = 1'b1;
                    // CBZ behind a load needs a second bubble, which must not depend on re-detection.
                    if (cbzLoad) begin
                        stateNext     = HOLD;
                        stallLeftNext = 2'd1;
                    end
                end
            end
            HOLD: begin
                stall         = 1'b1;
                stallLeftNext = stallLeft - 2'd1;
                if (stallLeft <= 2'd1) begin
                    stallLeftNext = 2'd0;
                    stateNext     = RUN;
                end
            end
            default: begin
                stateNext     = RUN;
                stallLeftNext = 2'd0;
            end
        endcase

        // A busy memory freezes everything, including the remaining-stall count.
        if (hz.MemBusy) begin
            stateNext     = state;
            stallLeftNext = stallLeft;
        end

        hz.PCWrite   = ~stall;
        hz.IFIDWrite = ~stall;
        hz.BubbleID  = stall;
        hz.FlushIFID = hz.BranchTakenID & ~stall;

        if (hz.MemBusy) begin
            hz.PCWrite   = 1'b0;
            hz.IFIDWrite = 1'b0;
            hz.BubbleID  = 1'b0;
            hz.FlushIFID = 1'b0;
        end

        if (reset) begin
            hz.PCWrite   = 1'b0;
            hz.IFIDWrite = 1'b0;
            hz.BubbleID  = 1'b1;
            hz.FlushIFID = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic stallCycle;
    logic flushCycle;

    // Count only cycles that actually present a stall or flush to the pipeline.
    assign stallCycle = stall & ~hz.MemBusy & ~reset;
    assign flushCycle = hz.BranchTakenID & ~stall & ~hz.MemBusy & ~reset;

    sat_counter #(.Width(CountW)) uStallCnt (
        .clk   (clk),
        .reset (reset),
        .en    (stallCycle),
        .count (hz.StallCount)
    );

    sat_counter #(.Width(CountW)) uFlushCnt (
        .clk   (clk),
        .reset (reset),
        .en    (flushCycle),
        .count (hz.FlushCount)
    );
`else
    assign hz.StallCount = '0;
    assign hz.FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: table of single-cycle vectors in RUN
// plus directed multi-cycle sequences (HOLD, freeze, reset, saturation).
module tb_hazard_unit;

    localparam logic [3:0] RUNOK  = 4'b1100; // {PCWrite, IFIDWrite, BubbleID, FlushIFID}
    localparam logic [3:0] STALL  = 4'b0010;
    localparam logic [3:0] FLUSH  = 4'b1101;
    localparam logic [3:0] FROZEN = 4'b0000;
    localparam logic [3:0] RST    = 4'b0011;

    typedef struct {
        logic       mrEX;
        logic       rwEX;
        logic [4:0] wrEX;
        logic       mrMEM;
        logic [4:0] wrMEM;
        logic [4:0] rn;
        logic [4:0] rm;
        logic [4:0] rt;
        logic       rmV;
        logic       zb;
        logic       bt;
        logic       busy;
        logic [3:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    hazard_unit_if hz ();

    hazard_unit dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic mrEX, input logic rwEX, input logic [4:0] wrEX,
                                input logic mrMEM, input logic [4:0] wrMEM,
                                input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rt,
                                input logic rmV, input logic zb, input logic bt, input logic busy,
                                input logic [3:0] exp);
        vec_t v;
        v.mrEX = mrEX; v.rwEX = rwEX; v.wrEX = wrEX; v.mrMEM = mrMEM; v.wrMEM = wrMEM;
        v.rn = rn; v.rm = rm; v.rt = rt; v.rmV = rmV; v.zb = zb; v.bt = bt; v.busy = busy;
        v.exp = exp;
        return v;
    endfunction

    function automatic logic [15:0] perf(input int n);
`ifdef HAZARD_PERF_EN
        return 16'(n);
`else
        return (n == 0) ? 16'd0 : 16'd0;
`endif
    endfunction

    task automatic setIn(input vec_t v);
        hz.MemReadEX     = v.mrEX;
        hz.RegWriteEX    = v.rwEX;
        hz.WriteRegEX    = v.wrEX;
        hz.MemReadMEM    = v.mrMEM;
        hz.WriteRegMEM   = v.wrMEM;
        hz.RnID          = v.rn;
        hz.RmID          = v.rm;
        hz.RtID          = v.rt;
        hz.RmValidID     = v.rmV;
        hz.ZeroBranchID  = v.zb;
        hz.BranchTakenID = v.bt;
        hz.MemBusy       = v.busy;
    endtask

    task automatic chkOut(input string nm, input logic [3:0] exp);
        logic [3:0] act;
        act = {hz.PCWrite, hz.IFIDWrite, hz.BubbleID, hz.FlushIFID};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ctrl{pc,ifid,bub,flush} got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chkCnt(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s count got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        setIn(mk(0,0,10,0,11,1,2,4,0,0,0,0,RUNOK));
        step();
        reset = 1'b0;
    endtask

    vec_t vecs[18];
    vec_t idle;
    vec_t cbzLd;

    initial begin
        idle  = mk(0,0,10,0,11,1,2,4,0,0,0,0,RUNOK);
        cbzLd = mk(1,1,5,0,11,1,2,5,0,1,0,0,STALL);

        vecs[0]  = mk(0,0,10,0,11, 1, 2, 4,0,0,0,0,RUNOK);  // idle
        vecs[1]  = mk(1,1, 3,0,11, 3, 2, 4,0,0,0,0,STALL);  // load-use on Rn
        vecs[2]  = mk(1,1, 7,0,11, 1, 7, 4,1,0,0,0,STALL);  // load-use on Rm
        vecs[3]  = mk(1,1, 7,0,11, 1, 7, 4,0,0,0,0,RUNOK);  // Rm match but not read
        vecs[4]  = mk(1,1,31,0,11,31, 2, 4,0,0,0,0,RUNOK);  // XZR on Rn
        vecs[5]  = mk(1,1,31,0,11, 1,31, 4,1,0,0,0,RUNOK);  // XZR on Rm
        vecs[6]  = mk(0,1, 5,0,11, 1, 2, 5,0,1,0,0,STALL);  // CBZ after ALU write
        vecs[7]  = mk(0,1,31,0,11, 1, 2,31,0,1,0,0,RUNOK);  // CBZ on XZR
        vecs[8]  = mk(0,0,10,1, 9, 1, 2, 9,0,1,0,0,STALL);  // CBZ, load in MEM
        vecs[9]  = mk(0,0,10,1, 9, 9, 2, 9,0,0,0,0,RUNOK);  // MEM load, no CBZ
        vecs[10] = mk(0,1, 3,0,11, 3, 3, 3,1,0,0,0,RUNOK);  // ALU producer, forwarded
        vecs[11] = mk(0,0, 5,0,11, 1, 2, 5,0,1,0,0,RUNOK);  // CBZ, EX not writing
        vecs[12] = mk(0,0,10,0,11, 1, 2, 4,0,0,1,0,FLUSH);  // taken branch
        vecs[13] = mk(1,1, 3,0,11, 3, 2, 4,0,0,1,0,STALL);  // taken branch during stall
        vecs[14] = mk(1,1, 3,0,11, 3, 2, 4,0,0,0,1,FROZEN); // busy over load-use
        vecs[15] = mk(0,0,10,0,11, 1, 2, 4,0,0,1,1,FROZEN); // busy over branch
        vecs[16] = mk(0,0,10,1,31, 1, 2,31,0,1,0,0,RUNOK);  // CBZ, MEM load to XZR
        vecs[17] = mk(0,0,10,0, 9, 1, 2, 9,0,1,0,0,RUNOK);  // CBZ, MEM not a load

        // Reset state
        setIn(idle);
        @(negedge clk);
        #2;
        chkOut("reset_outputs", RST);
        chkCnt("reset_stallcnt", hz.StallCount, 16'd0);
        chkCnt("reset_flushcnt", hz.FlushCount, 16'd0);
        reset = 1'b0;

        // Single-cycle vectors from RUN
        foreach (vecs[i]) begin
            setIn(vecs[i]);
            #2;
            chkOut($sformatf("vec%0d", i), vecs[i].exp);
            step();
        end

        // Load-use: one bubble, then load moves to MEM and pipeline resumes
        doReset();
        setIn(vecs[1]);
        #2 chkOut("lu_stall", STALL);
        step();
        setIn(mk(0,0,10,1,3,3,2,4,0,0,0,0,RUNOK));
        #2 chkOut("lu_resume", RUNOK);
        chkCnt("lu_stallcnt", hz.StallCount, perf(1));

        // CBZ after load: two stalls, second one independent of inputs
        doReset();
        setIn(cbzLd);
        #2 chkOut("cbzld_stall1", STALL);
        step();
        setIn(mk(0,0,10,0,11,1,2,5,0,1,0,0,RUNOK));
        #2 chkOut("cbzld_stall2", STALL);
        step();
        #2 chkOut("cbzld_run", RUNOK);
        chkCnt("cbzld_stallcnt", hz.StallCount, perf(2));

        // Taken branch flush count
        doReset();
        setIn(vecs[12]);
        #2 chkOut("br_flush", FLUSH);
        step();
        setIn(idle);
        #2 chkOut("br_after", RUNOK);
        chkCnt("br_flushcnt", hz.FlushCount, perf(1));
        chkCnt("br_stallcnt", hz.StallCount, perf(0));

        // MemBusy freeze while in HOLD
        doReset();
        setIn(cbzLd);
        #2 chkOut("busy_enter", STALL);
        step();
        for (int k = 0; k < 3; k++) begin
            setIn(mk(0,0,10,0,11,1,2,4,0,0,0,1,FROZEN));
            #2 chkOut($sformatf("busy_frz%0d", k), FROZEN);
            step();
        end
        setIn(idle);
        #2 chkOut("busy_release", STALL);
        step();
        #2 chkOut("busy_run", RUNOK);
        chkCnt("busy_stallcnt", hz.StallCount, perf(2));

        // Reset in HOLD with MemBusy: reset wins, HOLD abandoned
        doReset();
        setIn(cbzLd);
        #2 chkOut("rsthold_enter", STALL);
        step();
        reset = 1'b1;
        setIn(mk(0,0,10,0,11,1,2,4,0,0,0,1,FROZEN));
        #2 chkOut("rsthold_busy", RST);
        step();
        reset = 1'b0;
        setIn(idle);
        #2 chkOut("rsthold_run", RUNOK);
        chkCnt("rsthold_stallcnt", hz.StallCount, 16'd0);
        chkCnt("rsthold_flushcnt", hz.FlushCount, 16'd0);

        // Saturation under a continuous load-use stall
        setIn(vecs[1]);
        for (int k = 0; k < 65540; k++) @(posedge clk);
        @(negedge clk);
        #2 chkOut("sat_stall", STALL);
        chkCnt("sat_stallcnt", hz.StallCount, perf(65535));
        step();
        #2 chkCnt("sat_hold", hz.StallCount, perf(65535));
        chkCnt("sat_flushcnt", hz.FlushCount, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
